obi_to_axil_master: RTL and testbench

- Single-outstanding bridge from the core's OBI-style data port (req/gnt/rvalid) to an AXI4-lite master interface.
- Its AXI-lite master port drives the s00 slave port of the 1x3 AXI-lite interconnect directly.
- Converts each granted core request into one AXI-lite read (AR/R) or write (AW+W/B) transaction.
- Returns rdata and an error flag to the core.

---
 rtl/obi_to_axil_master.sv | 178 +++++++++++++++++
 tb/tb_obi_to_axil_master.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_to_axil_master.sv
// Single-outstanding bridge: OBI-style core data port (req/gnt/rvalid) to an AXI4-lite master.
// Each granted request becomes one AXI-lite read (AR/R) or write (AW+W/B) transaction.
module obi_to_axil_master #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8,
   parameter logic [2:0]  AXI_PROT   = 3'b000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   // core side
   input  logic                  data_req_i,
   output logic                  data_gnt_o,
   input  logic                  data_we_i,
   input  logic [STRB_WIDTH-1:0] data_be_i,
   input  logic [31:0]           data_addr_i,
   input  logic [DATA_WIDTH-1:0] data_wdata_i,
   output logic                  data_rvalid_o,
   output logic [DATA_WIDTH-1:0] data_rdata_o,
   output logic                  data_err_o,
   // AXI-lite write address
   output logic [ADDR_WIDTH-1:0] m_axil_awaddr,
   output logic [2:0]            m_axil_awprot,
   output logic                  m_axil_awvalid,
   input  logic                  m_axil_awready,
   // AXI-lite write data
   output logic [DATA_WIDTH-1:0] m_axil_wdata,
   output logic [STRB_WIDTH-1:0] m_axil_wstrb,
   output logic                  m_axil_wvalid,
   input  logic                  m_axil_wready,
   // AXI-lite write response
   input  logic [1:0]            m_axil_bresp,
   input  logic                  m_axil_bvalid,
   output logic                  m_axil_bready,
   // AXI-lite read address
   output logic [ADDR_WIDTH-1:0] m_axil_araddr,
   output logic [2:0]            m_axil_arprot,
   output logic                  m_axil_arvalid,
   input  logic                  m_axil_arready,
   // AXI-lite read data
   input  logic [DATA_WIDTH-1:0] m_axil_rdata,
   input  logic [1:0]            m_axil_rresp,
   input  logic                  m_axil_rvalid,
   output logic                  m_axil_rready
);

   typedef enum logic [2:0] {
      IDLE,
      WR_ADDR_DATA,
      WR_RESP,
      RD_ADDR,
      RD_DATA
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
   logic [STRB_WIDTH-1:0]   wstrb_q, wstrb_d;
   logic                    awvalid_q, awvalid_d;
   logic                    wvalid_q, wvalid_d;
   logic                    arvalid_q, arvalid_d;
   logic                    rvalid_q, rvalid_d;
   logic                    err_q, err_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic                    aw_done, w_done;

   // Address bits above the AXI window, the sub-word offset and the low resp bits carry no meaning here.
   logic unused_bits;
   assign unused_bits = ^{data_addr_i[31:ADDR_WIDTH], data_addr_i[1:0],
                          m_axil_bresp[0], m_axil_rresp[0]};

   assign data_gnt_o = data_req_i && (state_q == IDLE);

   // A channel counts as done if it already handshook earlier or is handshaking now.
   assign aw_done = !awvalid_q || m_axil_awready;
   assign w_done  = !wvalid_q  || m_axil_wready;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      arvalid_d = arvalid_q;
      rdata_d   = rdata_q;
      rvalid_d  = 1'b0;
      err_d     = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (data_req_i) begin
               addr_d  = {data_addr_i[ADDR_WIDTH-1:2], 2'b00};
               wdata_d = data_wdata_i;
               wstrb_d = data_be_i;
               if (data_we_i) begin
                  awvalid_d = 1'b1;
                  wvalid_d  = 1'b1;
                  state_d   = WR_ADDR_DATA;
               end else begin
                  arvalid_d = 1'b1;
                  state_d   = RD_ADDR;
               end
            end
         end
         WR_ADDR_DATA: begin
            if (awvalid_q && m_axil_awready) awvalid_d = 1'b0;
            if (wvalid_q && m_axil_wready)   wvalid_d  = 1'b0;
            if (aw_done && w_done)           state_d   = WR_RESP;
         end
         WR_RESP: begin
            if (m_axil_bvalid) begin
               rvalid_d = 1'b1;
               err_d    = m_axil_bresp[1];
               state_d  = IDLE;
            end
         end
         RD_ADDR: begin
            if (m_axil_arready) begin
               arvalid_d = 1'b0;
               state_d   = RD_DATA;
            end
         end
         RD_DATA: begin
            if (m_axil_rvalid) begin
               rdata_d  = m_axil_rdata;
               rvalid_d = 1'b1;
               err_d    = m_axil_rresp[1];
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         wstrb_q   <= '0;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rvalid_q  <= 1'b0;
         err_q     <= 1'b0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         arvalid_q <= arvalid_d;
         rvalid_q  <= rvalid_d;
         err_q     <= err_d;
         rdata_q   <= rdata_d;
      end
   end

   assign m_axil_awaddr  = addr_q;
   assign m_axil_awprot  = AXI_PROT;
   assign m_axil_awvalid = awvalid_q;
   assign m_axil_wdata   = wdata_q;
   assign m_axil_wstrb   = wstrb_q;
   assign m_axil_wvalid  = wvalid_q;
   assign m_axil_bready  = (state_q == WR_RESP);
   assign m_axil_araddr  = addr_q;
   assign m_axil_arprot  = AXI_PROT;
   assign m_axil_arvalid = arvalid_q;
   assign m_axil_rready  = (state_q == RD_DATA);

   assign data_rvalid_o  = rvalid_q;
   assign data_rdata_o   = rdata_q;
   assign data_err_o     = err_q;

endmodule

// File: tb/tb_obi_to_axil_master.sv
// Directed bench for obi_to_axil_master: inputs change just after the falling edge,
// outputs are checked 1 time unit later, well away from the rising edge.
module tb_obi_to_axil_master;

   logic        clk;
   logic        rst_n;
   logic        data_req_i;
   logic        data_gnt_o;
   logic        data_we_i;
   logic [3:0]  data_be_i;
   logic [31:0] data_addr_i;
   logic [31:0] data_wdata_i;
   logic        data_rvalid_o;
   logic [31:0] data_rdata_o;
   logic        data_err_o;
   logic [15:0] m_axil_awaddr;
   logic [2:0]  m_axil_awprot;
   logic        m_axil_awvalid;
   logic        m_axil_awready;
   logic [31:0] m_axil_wdata;
   logic [3:0]  m_axil_wstrb;
   logic        m_axil_wvalid;
   logic        m_axil_wready;
   logic [1:0]  m_axil_bresp;
   logic        m_axil_bvalid;
   logic        m_axil_bready;
   logic [15:0] m_axil_araddr;
   logic [2:0]  m_axil_arprot;
   logic        m_axil_arvalid;
   logic        m_axil_arready;
   logic [31:0] m_axil_rdata;
   logic [1:0]  m_axil_rresp;
   logic        m_axil_rvalid;
   logic        m_axil_rready;

   int checks_cnt = 0;
   int errors_cnt = 0;

   obi_to_axil_master dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .data_req_i     (data_req_i),
      .data_gnt_o     (data_gnt_o),
      .data_we_i      (data_we_i),
      .data_be_i      (data_be_i),
      .data_addr_i    (data_addr_i),
      .data_wdata_i   (data_wdata_i),
      .data_rvalid_o  (data_rvalid_o),
      .data_rdata_o   (data_rdata_o),
      .data_err_o     (data_err_o),
      .m_axil_awaddr  (m_axil_awaddr),
      .m_axil_awprot  (m_axil_awprot),
      .m_axil_awvalid (m_axil_awvalid),
      .m_axil_awready (m_axil_awready),
      .m_axil_wdata   (m_axil_wdata),
      .m_axil_wstrb   (m_axil_wstrb),
      .m_axil_wvalid  (m_axil_wvalid),
      .m_axil_wready  (m_axil_wready),
      .m_axil_bresp   (m_axil_bresp),
      .m_axil_bvalid  (m_axil_bvalid),
      .m_axil_bready  (m_axil_bready),
      .m_axil_araddr  (m_axil_araddr),
      .m_axil_arprot  (m_axil_arprot),
      .m_axil_arvalid (m_axil_arvalid),
      .m_axil_arready (m_axil_arready),
      .m_axil_rdata   (m_axil_rdata),
      .m_axil_rresp   (m_axil_rresp),
      .m_axil_rvalid  (m_axil_rvalid),
      .m_axil_rready  (m_axil_rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_cnt++;
      if (got !== exp) begin
         errors_cnt++;
         $display("FAIL %s got=0x%08h exp=0x%08h t=%0t", tag, got, exp, $time);
      end else begin
         $display("ok   %s = 0x%08h t=%0t", tag, got, $time);
      end
   endtask

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic core_req(input logic we, input logic [31:0] addr,
                           input logic [3:0] be, input logic [31:0] wd);
      data_req_i   = 1'b1;
      data_we_i    = we;
      data_addr_i  = addr;
      data_be_i    = be;
      data_wdata_i = wd;
   endtask

   initial begin
      rst_n = 1'b0;
      data_req_i = 0; data_we_i = 0; data_be_i = 0; data_addr_i = 0; data_wdata_i = 0;
      m_axil_awready = 0; m_axil_wready = 0; m_axil_bresp = 0; m_axil_bvalid = 0;
      m_axil_arready = 0; m_axil_rdata = 0; m_axil_rresp = 0; m_axil_rvalid = 0;

      // ---------------- reset state
      cyc(); #1;
      check("rst_awvalid", {31'd0, m_axil_awvalid}, 32'd0);
      check("rst_wvalid",  {31'd0, m_axil_wvalid},  32'd0);
      check("rst_arvalid", {31'd0, m_axil_arvalid}, 32'd0);
      check("rst_bready",  {31'd0, m_axil_bready},  32'd0);
      check("rst_rready",  {31'd0, m_axil_rready},  32'd0);
      check("rst_rvalid",  {31'd0, data_rvalid_o},  32'd0);
      check("rst_rdata",   data_rdata_o, 32'd0);
      check("rst_prot",    {29'd0, m_axil_awprot}, 32'd0);
      cyc(); rst_n = 1'b1;

      // ---------------- test 1: zero-wait write
      cyc(); core_req(1'b1, 32'h0000_1006, 4'b1100, 32'hDEAD_BEEF);
      m_axil_awready = 1; m_axil_wready = 1; #1;
      check("t1_gnt", {31'd0, data_gnt_o}, 32'd1);
      cyc(); data_req_i = 0; #1;
      check("t1_awvalid", {31'd0, m_axil_awvalid}, 32'd1);
      check("t1_wvalid",  {31'd0, m_axil_wvalid},  32'd1);
      check("t1_awaddr",  {16'd0, m_axil_awaddr}, 32'h0000_1004);
      check("t1_wstrb",   {28'd0, m_axil_wstrb},  32'hC);
      check("t1_wdata",   m_axil_wdata, 32'hDEAD_BEEF);
      cyc(); m_axil_bvalid = 1; m_axil_bresp = 2'b00; #1;
      check("t1_bready",   {31'd0, m_axil_bready},  32'd1);
      check("t1_awv_drop", {31'd0, m_axil_awvalid}, 32'd0);
      check("t1_wv_drop",  {31'd0, m_axil_wvalid},  32'd0);
      cyc(); m_axil_bvalid = 0; m_axil_awready = 0; m_axil_wready = 0; #1;
      check("t1_rvalid", {31'd0, data_rvalid_o}, 32'd1);
      check("t1_err",    {31'd0, data_err_o},    32'd0);
      cyc(); #1;
      check("t1_rvalid_pulse", {31'd0, data_rvalid_o}, 32'd0);

      // ---------------- test 2: read, arready after 3 stall cycles, rvalid after 2
      cyc(); core_req(1'b0, 32'hABCD_2009, 4'hF, 32'h0); #1;
      check("t2_gnt", {31'd0, data_gnt_o}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         cyc(); data_req_i = 0; #1;
         check("t2_arvalid_stall", {31'd0, m_axil_arvalid}, 32'd1);
         check("t2_araddr_stall",  {16'd0, m_axil_araddr}, 32'h0000_2008);
      end
      cyc(); m_axil_arready = 1; #1;
      check("t2_arvalid_hs", {31'd0, m_axil_arvalid}, 32'd1);
      check("t2_araddr_hs",  {16'd0, m_axil_araddr}, 32'h0000_2008);
      for (int i = 0; i < 2; i++) begin
         cyc(); m_axil_arready = 0; #1;
         check("t2_arvalid_off", {31'd0, m_axil_arvalid}, 32'd0);
         check("t2_rready", {31'd0, m_axil_rready}, 32'd1);
         check("t2_no_rvalid", {31'd0, data_rvalid_o}, 32'd0);
      end
      cyc(); m_axil_rvalid = 1; m_axil_rdata = 32'h1234_5678; m_axil_rresp = 2'b00; #1;
      cyc(); m_axil_rvalid = 0; #1;
      check("t2_rvalid", {31'd0, data_rvalid_o}, 32'd1);
      check("t2_rdata",  data_rdata_o, 32'h1234_5678);
      check("t2_err",    {31'd0, data_err_o}, 32'd0);
      cyc(); #1;
      check("t2_rvalid_pulse", {31'd0, data_rvalid_o}, 32'd0);

      // ---------------- test 3: split write handshake, W first then AW, bresp SLVERR
      cyc(); core_req(1'b1, 32'h0000_0030, 4'hF, 32'hA5A5_0001); #1;
      check("t3_gnt", {31'd0, data_gnt_o}, 32'd1);
      cyc(); data_req_i = 0; m_axil_wready = 1; #1;
      check("t3_wvalid_t1", {31'd0, m_axil_wvalid}, 32'd1);
      cyc(); m_axil_wready = 0; #1;
      check("t3_wvalid_t2",  {31'd0, m_axil_wvalid},  32'd0);
      check("t3_awvalid_t2", {31'd0, m_axil_awvalid}, 32'd1);
      check("t3_bready_t2",  {31'd0, m_axil_bready},  32'd0);
      cyc(); #1;
      check("t3_awvalid_t3", {31'd0, m_axil_awvalid}, 32'd1);
      check("t3_awaddr_t3",  {16'd0, m_axil_awaddr}, 32'h0000_0030);
      cyc(); m_axil_awready = 1; #1;
      check("t3_awvalid_t4", {31'd0, m_axil_awvalid}, 32'd1);
      check("t3_bready_t4",  {31'd0, m_axil_bready},  32'd0);
      cyc(); m_axil_awready = 0; m_axil_bvalid = 1; m_axil_bresp = 2'b10; #1;
      check("t3_awvalid_t5", {31'd0, m_axil_awvalid}, 32'd0);
      check("t3_bready_t5",  {31'd0, m_axil_bready},  32'd1);
      cyc(); m_axil_bvalid = 0; #1;
      check("t3_rvalid", {31'd0, data_rvalid_o}, 32'd1);
      check("t3_err",    {31'd0, data_err_o}, 32'd1);
      check("t3_rdata_kept", data_rdata_o, 32'h1234_5678);
      cyc(); #1;
      check("t3_err_clr", {31'd0, data_err_o}, 32'd0);

      // ---------------- test 4: read with DECERR
      cyc(); core_req(1'b0, 32'h0000_0044, 4'hF, 32'h0); m_axil_arready = 1; #1;
      check("t4_gnt", {31'd0, data_gnt_o}, 32'd1);
      cyc(); data_req_i = 0; #1;
      check("t4_arvalid", {31'd0, m_axil_arvalid}, 32'd1);
      cyc(); m_axil_arready = 0; m_axil_rvalid = 1; m_axil_rresp = 2'b11;
      m_axil_rdata = 32'hFFFF_FFFF; #1;
      check("t4_rready", {31'd0, m_axil_rready}, 32'd1);
      cyc(); m_axil_rvalid = 0; m_axil_rresp = 2'b00; #1;
      check("t4_rvalid", {31'd0, data_rvalid_o}, 32'd1);
      check("t4_err",    {31'd0, data_err_o}, 32'd1);
      check("t4_rdata",  data_rdata_o, 32'hFFFF_FFFF);

      // ---------------- test 5: back-to-back, req held: read then write
      cyc(); core_req(1'b0, 32'h0000_0050, 4'hF, 32'h0); m_axil_arready = 1; #1;
      check("t5_gnt_rd", {31'd0, data_gnt_o}, 32'd1);
      cyc(); core_req(1'b1, 32'h0000_0060, 4'h3, 32'h0BAD_F00D); #1;
      check("t5_busy_gnt1", {31'd0, data_gnt_o}, 32'd0);
      cyc(); m_axil_arready = 0; m_axil_rvalid = 1; m_axil_rdata = 32'hCAFE_0001; #1;
      check("t5_busy_gnt2", {31'd0, data_gnt_o}, 32'd0);
      cyc(); m_axil_rvalid = 0; m_axil_awready = 1; m_axil_wready = 1; #1;
      check("t5_rvalid_rd", {31'd0, data_rvalid_o}, 32'd1);
      check("t5_rdata_rd",  data_rdata_o, 32'hCAFE_0001);
      check("t5_gnt_wr",    {31'd0, data_gnt_o}, 32'd1);
      cyc(); data_req_i = 0; #1;
      check("t5_awvalid", {31'd0, m_axil_awvalid}, 32'd1);
      check("t5_awaddr",  {16'd0, m_axil_awaddr}, 32'h0000_0060);
      check("t5_wdata",   m_axil_wdata, 32'h0BAD_F00D);
      check("t5_wstrb",   {28'd0, m_axil_wstrb}, 32'h3);
      check("t5_rvalid_gap", {31'd0, data_rvalid_o}, 32'd0);
      cyc(); m_axil_bvalid = 1; m_axil_bresp = 2'b00; #1;
      check("t5_bready", {31'd0, m_axil_bready}, 32'd1);
      cyc(); m_axil_bvalid = 0; m_axil_awready = 0; m_axil_wready = 0; #1;
      check("t5_rvalid_wr", {31'd0, data_rvalid_o}, 32'd1);
      check("t5_err_wr",    {31'd0, data_err_o}, 32'd0);
      check("t5_rdata_kept", data_rdata_o, 32'hCAFE_0001);

      // ---------------- test 6: async reset while in WR_RESP
      cyc(); core_req(1'b1, 32'h0000_0070, 4'hF, 32'h1111_2222);
      m_axil_awready = 1; m_axil_wready = 1; #1;
      check("t6_gnt", {31'd0, data_gnt_o}, 32'd1);
      cyc(); data_req_i = 0; #1;
      cyc(); #1;
      check("t6_bready_pre", {31'd0, m_axil_bready}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check("t6_rst_bready",  {31'd0, m_axil_bready},  32'd0);
      check("t6_rst_awvalid", {31'd0, m_axil_awvalid}, 32'd0);
      check("t6_rst_wvalid",  {31'd0, m_axil_wvalid},  32'd0);
      check("t6_rst_rvalid",  {31'd0, data_rvalid_o},  32'd0);
      check("t6_rst_rdata",   data_rdata_o, 32'd0);
      check("t6_rst_awaddr",  {16'd0, m_axil_awaddr}, 32'd0);
      cyc(); rst_n = 1'b1; m_axil_awready = 0; m_axil_wready = 0;
      m_axil_bvalid = 1; #1;
      cyc(); m_axil_bvalid = 0; #1;
      check("t6_stray_b_ignored", {31'd0, data_rvalid_o}, 32'd0);
      cyc(); core_req(1'b0, 32'h0000_0084, 4'hF, 32'h0); m_axil_arready = 1; #1;
      check("t6_gnt_rd", {31'd0, data_gnt_o}, 32'd1);
      cyc(); data_req_i = 0; #1;
      check("t6_araddr", {16'd0, m_axil_araddr}, 32'h0000_0084);
      cyc(); m_axil_arready = 0; m_axil_rvalid = 1; m_axil_rdata = 32'h5555_AAAA; #1;
      cyc(); m_axil_rvalid = 0; #1;
      check("t6_rvalid", {31'd0, data_rvalid_o}, 32'd1);
      check("t6_rdata",  data_rdata_o, 32'h5555_AAAA);
      check("t6_err",    {31'd0, data_err_o}, 32'd0);

      cyc();
      $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
      $finish;
   end

endmodule
